// File: rtl/seg_pkg.sv
// Shared constants, state type and small helpers for the seven-segment readback path.
package seg_pkg;

  localparam int NUM_DIGITS = 4;

  // Segment patterns, bit6=g .. bit0=a, active-high.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_HEX_0 = 7'b0111111;
  localparam logic [6:0] SEG_HEX_1 = 7'b0000110;
  localparam logic [6:0] SEG_HEX_2 = 7'b1011011;
  localparam logic [6:0] SEG_HEX_3 = 7'b1001111;
  localparam logic [6:0] SEG_HEX_4 = 7'b1100110;
  localparam logic [6:0] SEG_HEX_5 = 7'b1101101;
  localparam logic [6:0] SEG_HEX_6 = 7'b1111101;
  localparam logic [6:0] SEG_HEX_7 = 7'b0000111;
  localparam logic [6:0] SEG_HEX_8 = 7'b1111111;
  localparam logic [6:0] SEG_HEX_9 = 7'b1101111;
  localparam logic [6:0] SEG_HEX_A = 7'b1110111;
  localparam logic [6:0] SEG_HEX_B = 7'b1111100;
  localparam logic [6:0] SEG_HEX_C = 7'b0111001;
  localparam logic [6:0] SEG_HEX_D = 7'b1011110;
  localparam logic [6:0] SEG_HEX_E = 7'b1111001;
  localparam logic [6:0] SEG_HEX_F = 7'b1110001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } seg_state_e;

  // True when exactly one strobe bit is set.
  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
  endfunction

  // Position of the set bit; only meaningful for a one-hot input.
  function automatic logic [1:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_readback_if.sv
// Display bus as seen by the readback monitor, plus its recovered-value outputs.
interface seg_readback_if;
  import seg_pkg::*;

  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    clr;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   valid;
  logic [NUM_DIGITS-1:0]   err;
  logic                    upd;
  logic [1:0]              upd_idx;

  // master: whoever drives the display bus and reads the results
  modport master (output an, seg, clr, input digits, valid, err, upd, upd_idx);
  // slave: the readback monitor
  modport slave  (input an, seg, clr, output digits, valid, err, upd, upd_idx);

endinterface

// File: rtl/seg_to_hex.sv
// Inverse of the hex-to-segment decoder: classifies a segment pattern.
module seg_to_hex
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] hex,
  output logic       is_hex,
  output logic       is_blank
);

  // Table lookup; anything not in the table is either blank or an error.
  always_comb begin
    hex      = 4'h0;
    is_hex   = 1'b1;
    is_blank = 1'b0;
    case (seg)
      SEG_HEX_0: hex = 4'h0;
      SEG_HEX_1: hex = 4'h1;
      SEG_HEX_2: hex = 4'h2;
      SEG_HEX_3: hex = 4'h3;
      SEG_HEX_4: hex = 4'h4;
      SEG_HEX_5: hex = 4'h5;
      SEG_HEX_6: hex = 4'h6;
      SEG_HEX_7: hex = 4'h7;
      SEG_HEX_8: hex = 4'h8;
      SEG_HEX_9: hex = 4'h9;
      SEG_HEX_A: hex = 4'hA;
      SEG_HEX_B: hex = 4'hB;
      SEG_HEX_C: hex = 4'hC;
      SEG_HEX_D: hex = 4'hD;
      SEG_HEX_E: hex = 4'hE;
      SEG_HEX_F: hex = 4'hF;
      SEG_BLANK: begin
        is_hex   = 1'b0;
        is_blank = 1'b1;
      end
      default:   is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_readback.sv
// Recovers the hex value shown on each digit of a multiplexed seven-segment bus.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | strobe not one-hot; nothing can be captured
//   SETTLE | one-hot strobe, waiting for STABLE_CYCLES identical samples
//   HOLD   | pattern captured; waiting for the bus to change
module seg_readback
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_readback_if.slave  bus
);

  localparam int SW = NUM_DIGITS + 7;

  logic [SW-1:0]           smp_in, smp_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  seg_state_e              state_q, state_d;
  logic                    same, an_ok, capture;
  logic [1:0]              cap_idx;
  logic [3:0]              dec_hex;
  logic                    dec_is_hex, dec_is_blank;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d, err_q, err_d;
  logic                    upd_q, upd_d;
  logic [1:0]              upd_idx_q, upd_idx_d;

  assign smp_in  = {bus.an, bus.seg};
  assign same    = (smp_in == smp_q);
  assign an_ok   = is_onehot(bus.an);
  assign cap_idx = onehot_idx(bus.an);

  seg_to_hex u_dec (
    .seg      (bus.seg),
    .hex      (dec_hex),
    .is_hex   (dec_is_hex),
    .is_blank (dec_is_blank)
  );

  // Stability counter: restarts at 1 on any change, saturates at STABLE_CYCLES.
  always_comb begin
    if (!same)                                 cnt_d = CNT_W'(1);
    else if (cnt_q == CNT_W'(STABLE_CYCLES))   cnt_d = cnt_q;
    else                                       cnt_d = cnt_q + CNT_W'(1);
  end

  // Sample register and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= '0;
      cnt_q <= '0;
    end else begin
      smp_q <= smp_in;
      cnt_q <= cnt_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state; a change that keeps the strobe one-hot always restarts settling.
  always_comb begin
    state_d = state_q;
    if (!an_ok)                          state_d = IDLE;
    else if (state_q == IDLE || !same)   state_d = SETTLE;
    else if (capture)                    state_d = HOLD;
  end

  // FSM outputs: capture strobe and next values of the result registers.
  always_comb begin
    capture   = (state_q == SETTLE) && an_ok && same &&
                (cnt_q == CNT_W'(STABLE_CYCLES - 1));
    digits_d  = digits_q;
    valid_d   = bus.clr ? '0 : valid_q;
    err_d     = bus.clr ? '0 : err_q;
    upd_d     = capture;
    upd_idx_d = upd_idx_q;
    if (capture) begin
      upd_idx_d        = cap_idx;
      valid_d[cap_idx] = dec_is_hex;
      err_d[cap_idx]   = !dec_is_hex && !dec_is_blank;
      if (dec_is_hex) digits_d[{cap_idx, 2'b00} +: 4] = dec_hex;
    end
  end

  // Result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q  <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= 2'd0;
    end else begin
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
    end
  end

  assign bus.digits  = digits_q;
  assign bus.valid   = valid_q;
  assign bus.err     = err_q;
  assign bus.upd     = upd_q;
  assign bus.upd_idx = upd_idx_q;

endmodule

// File: tb/tb_seg_readback.sv
module tb_seg_readback;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_readback_if bus();

  seg_readback #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;
  int pulses = 0;

  // Reference segment table, index = hex value.
  logic [6:0] hex_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Behavioural model: a pattern is captured on the edge where it has been
  // seen on S consecutive edges with a single strobe bit set.
  logic [10:0] m_prev = '0;
  int          m_run = 0;
  logic [15:0] m_digits = '0;
  logic [3:0]  m_valid = '0;
  logic [3:0]  m_err = '0;
  logic        m_upd = 1'b0;
  logic [1:0]  m_idx = '0;
  int          m_hit;
  int          m_pos;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = '0; m_run = 0; m_digits = '0; m_valid = '0; m_err = '0;
      m_upd = 1'b0; m_idx = '0;
    end else begin
      if ({bus.an, bus.seg} == m_prev) m_run++;
      else m_run = 1;
      m_prev = {bus.an, bus.seg};
      m_upd = 1'b0;
      if (bus.clr) begin m_valid = '0; m_err = '0; end
      if ($countones(bus.an) == 1 && m_run == S) begin
        m_pos = 0;
        for (int i = 0; i < 4; i++) if (bus.an[i]) m_pos = i;
        m_hit = -1;
        for (int k = 0; k < 16; k++) if (bus.seg == hex_tab[k]) m_hit = k;
        m_upd = 1'b1;
        m_idx = 2'(m_pos);
        if (m_hit >= 0) begin
          m_digits[4*m_pos +: 4] = 4'(m_hit);
          m_valid[m_pos] = 1'b1;
          m_err[m_pos] = 1'b0;
        end else begin
          m_valid[m_pos] = 1'b0;
          m_err[m_pos] = (bus.seg != 7'b0);
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("digits", 32'(bus.digits), 32'(m_digits));
    chk("valid", 32'(bus.valid), 32'(m_valid));
    chk("err", 32'(bus.err), 32'(m_err));
    chk("upd", 32'(bus.upd), 32'(m_upd));
    if (m_upd) chk("upd_idx", 32'(bus.upd_idx), 32'(m_idx));
    if (bus.upd === 1'b1) pulses++;
  end

  task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n, input logic c = 1'b0);
    for (int i = 0; i < n; i++) begin
      bus.an = a; bus.seg = s; bus.clr = c;
      @(posedge clk);
      #1;
    end
    bus.clr = 1'b0;
  endtask

  int p0;

  initial begin
    bus.an = '0; bus.seg = '0; bus.clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_digits", 32'(bus.digits), 32'h0);
    chk("rst_valid", 32'(bus.valid), 32'h0);
    chk("rst_err", 32'(bus.err), 32'h0);
    chk("rst_upd", 32'(bus.upd), 32'h0);
    chk("rst_upd_idx", 32'(bus.upd_idx), 32'h0);
    rst_n = 1'b1;

    // basic capture of digit 0 = 2
    p0 = pulses;
    hold(4'b0001, 7'b1011011, 4);
    chk("t1_upd", 32'(bus.upd), 32'h1);
    chk("t1_idx", 32'(bus.upd_idx), 32'h0);
    chk("t1_dig0", 32'(bus.digits[3:0]), 32'h2);
    chk("t1_valid", 32'(bus.valid), 32'h1);
    hold(4'b0001, 7'b1011011, 6);
    chk("t1_pulses", 32'(pulses - p0), 32'd1);

    // glitch reject on digit 2, then 9
    p0 = pulses;
    hold(4'b0100, 7'b1111111, 3);
    hold(4'b0100, 7'b1101111, 6);
    chk("t2_pulses", 32'(pulses - p0), 32'd1);
    chk("t2_dig2", 32'(bus.digits[11:8]), 32'h9);
    chk("t2_valid2", 32'(bus.valid[2]), 32'h1);

    // error then blank on digit 3
    p0 = pulses;
    hold(4'b1000, 7'b1000000, 5);
    chk("t3_err", 32'(bus.err), 32'h8);
    chk("t3_valid3", 32'(bus.valid[3]), 32'h0);
    hold(4'b1000, 7'b0000000, 5);
    chk("t3_err_blank", 32'(bus.err), 32'h0);
    chk("t3_valid3_blank", 32'(bus.valid[3]), 32'h0);
    chk("t3_dig3", 32'(bus.digits[15:12]), 32'h0);
    chk("t3_pulses", 32'(pulses - p0), 32'd2);

    // multiplexed scan 1, A, d, F
    p0 = pulses;
    hold(4'b0001, 7'b0000110, 5);
    hold(4'b0010, 7'b1110111, 5);
    hold(4'b0100, 7'b1011110, 5);
    hold(4'b1000, 7'b1110001, 5);
    chk("t4_digits", 32'(bus.digits), 32'hFDA1);
    chk("t4_valid", 32'(bus.valid), 32'hF);
    chk("t4_pulses", 32'(pulses - p0), 32'd4);

    // non-one-hot strobes
    p0 = pulses;
    hold(4'b0011, 7'b0111111, 10);
    hold(4'b0000, 7'b0111111, 10);
    chk("t5_pulses", 32'(pulses - p0), 32'd0);
    chk("t5_digits", 32'(bus.digits), 32'hFDA1);

    // clr on the capture edge of digit 1 (value 5)
    hold(4'b0010, 7'b1101101, 3);
    hold(4'b0010, 7'b1101101, 1, 1'b1);
    chk("t6_valid", 32'(bus.valid), 32'h2);
    chk("t6_upd", 32'(bus.upd), 32'h1);
    chk("t6_digits", 32'(bus.digits), 32'hFD51);
    hold(4'b0010, 7'b1101101, 2);

    // reset during SETTLE
    hold(4'b0001, 7'b1001111, 2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_digits", 32'(bus.digits), 32'h0);
    chk("t6_rst_valid", 32'(bus.valid), 32'h0);
    chk("t6_rst_err", 32'(bus.err), 32'h0);
    chk("t6_rst_upd", 32'(bus.upd), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    p0 = pulses;
    hold(4'b0001, 7'b1001111, 2);
    hold(4'b0000, 7'b0000000, 4);
    chk("t6_post_rst_pulses", 32'(pulses - p0), 32'd0);
    chk("t6_post_rst_digits", 32'(bus.digits), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg_readback.md
Name: seg_readback

Overview:
- Monitors a multiplexed four-digit seven-segment bus (one-hot digit strobe plus shared segment lines) and recovers the hex value shown on each digit.
- Each pattern is accepted only after it has been stable for a set number of clocks. It is then converted back to 4-bit hex and stored per digit, with valid and error flags.
- Sits beside the display driver as the reverse path of the hex-to-segment decoder. Used for self-check and readback of what the lamp FSM is displaying.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before capture; legal range 2..255.
- CNT_W, 8: width of the stability counter; must satisfy 2^CNT_W > STABLE_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- an  in  4  digit strobe, active-high; exactly one bit set means a digit is selected.
- seg  in  7  segment lines, active-high, bit0=a .. bit6=g.
- clr  in  1  synchronous clear of the valid and err flags.
- digits  out  16  recovered hex values; digit i occupies bits [4i+3:4i].
- valid  out  4  per-digit flag: last capture was a legal hex pattern.
- err  out  4  per-digit flag: last capture was a non-blank, non-hex pattern.
- upd  out  1  one-cycle pulse on every capture.
- upd_idx  out  2  index of the digit captured; meaningful only while upd=1.

Behaviour:
- Reset (async, rst_n=0): digits=0, valid=0, err=0, upd=0, upd_idx=0, state=IDLE, cnt=0, sample register=0.
- Sampling: the {an,seg} sample register loads every edge.
  - If the incoming value differs from the register, cnt<=1.
  - Otherwise cnt increments, saturating at STABLE_CYCLES.
- FSM states:
  - IDLE: an not one-hot (zero or multiple bits set). Nothing is captured.
  - SETTLE: an is one-hot and cnt < STABLE_CYCLES.
  - HOLD: value captured; waiting for the bus to change.
- Transitions:
  - IDLE->SETTLE on the first edge with one-hot an.
  - SETTLE->HOLD on the edge where input equals the sample register and cnt==STABLE_CYCLES-1. That same edge performs the capture.
  - SETTLE->SETTLE with cnt<=1 on any change that keeps an one-hot.
  - HOLD->SETTLE (cnt<=1) on any change that keeps an one-hot.
  - Any state->IDLE when an becomes non-one-hot.
- Latency: inputs presented before edge k and held; capture happens at edge k+STABLE_CYCLES-1, and upd is high for exactly the following cycle.
- Only one capture occurs per stable period. Holding the bus unchanged in HOLD never re-pulses upd.
- Capture into digit i (i = index of the set an bit):
  - Legal hex pattern: digits[i]=hex value, valid[i]=1, err[i]=0.
  - Blank pattern 0000000: digits[i] unchanged, valid[i]=0, err[i]=0.
  - Any other pattern: digits[i] unchanged, valid[i]=0, err[i]=1.
  - In all cases upd=1 and upd_idx=i. Other digits are untouched.
- Hex table (g..a), canonical and one-to-one:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
- clr: clears all valid and err bits at the edge; digits are kept.
  - clr and a capture on the same edge: the captured digit takes the capture result; all other digits are cleared.
- Reset asserted mid-SETTLE or mid-HOLD: immediate return to reset values. No partial capture survives.

Decomposition:
- Package seg_pkg holds:
  - the 16 SEG_HEX_n pattern constants and SEG_BLANK;
  - the state enum {IDLE, SETTLE, HOLD};
  - NUM_DIGITS=4.
- Sub-module seg_to_hex (combinational): seg[6:0] -> hex[3:0], is_hex, is_blank. It is reused by the display-driver self-check bench.

Test Plan:
- Basic capture: an=0001, seg=1011011 held for 4 cycles -> upd pulse with upd_idx=0 after the 4th edge; digits[3:0]=2, valid=0001, no second pulse while held.
- Glitch reject: an=0100, seg=1111111 held for 3 cycles, then seg=1101111 held for 4 -> exactly one upd, digits[11:8]=9, valid[2]=1.
- Error and blank: an=1000, seg=1000000 held for 4 -> err=1000, valid[3]=0. Then seg=0000000 held for 4 -> err[3]=0, valid[3]=0, digits[15:12] unchanged.
- Multiplexed scan: cycle an 0001/0010/0100/1000 with hex patterns 1,A,d,F, each held for 5 cycles -> digits=16'hFDA1, valid=1111, four upd pulses with idx 0,1,2,3.
- Non-one-hot strobe: an=0011 or an=0000 with seg=0111111 held for 10 cycles -> no upd, state stays IDLE.
- clr and reset: clr on the capture edge of digit 1 with valid=1111 -> valid=0010. Then rst_n low during SETTLE -> all outputs 0 immediately, no upd after release.
